// File: rtl/car_cmd_tx_if.sv
// Button inputs and UART/status outputs of the car command transmitter.
// busy is high for exactly the cycles a frame occupies tx_pin; there is no back-pressure.
interface car_cmd_tx_if;
    logic        btn_fwd;
    logic        btn_back;
    logic        btn_left;
    logic        btn_right;
    logic        btn_center;
    logic        tx_pin;
    logic        busy;
    logic [7:0]  last_cmd;
    logic [15:0] cmd_count;
    logic [1:0]  state_dbg;

    modport master (
        output btn_fwd, btn_back, btn_left, btn_right, btn_center,
        input  tx_pin, busy, last_cmd, cmd_count, state_dbg
    );

    modport slave (
        input  btn_fwd, btn_back, btn_left, btn_right, btn_center,
        output tx_pin, busy, last_cmd, cmd_count, state_dbg
    );
endinterface

// File: rtl/car_cmd_tx.sv
// Push-button to command-byte encoder with an 8N1 UART transmitter,
// change-triggered sends and auto-repeat while steering is held.
module car_cmd_tx #(
    parameter int SYS_CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE     = 921600,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input logic         sys_clk,
    input logic         rst_n,
    car_cmd_tx_if.slave bus
);
    localparam int BAUD_DIV = SYS_CLK_FREQ / BAUD_RATE;
    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(BAUD_DIV - 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    localparam logic [2:0] M_FWD   = 3'b011;
    localparam logic [2:0] M_BACK  = 3'b110;
    localparam logic [2:0] M_HALT  = 3'b101;
    localparam logic [2:0] S_LEFT  = 3'b011;
    localparam logic [2:0] S_RIGHT = 3'b110;
    localparam logic [2:0] S_STR   = 3'b101;
    localparam logic [2:0] S_NONE  = 3'b000;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_d;

    // Button order: {center, right, left, back, fwd}
    logic [4:0]    btn_meta, btn_sync;
    logic [2:0]    motor, servo, prev_servo, sent_motor;
    logic          prev_center, steer, prev_steer, trigger, load, tmr_last;
    logic [7:0]    cmd_byte, shifter;
    logic [TW-1:0] bit_tmr;
    logic [2:0]    bit_idx;
    logic [RW-1:0] rpt_cnt;
    logic          pending, tx_q, busy_q;
    logic [7:0]    last_cmd_q;
    logic [15:0]   cmd_count_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= {bus.btn_center, bus.btn_right, bus.btn_left, bus.btn_back, bus.btn_fwd};
            btn_sync <= btn_meta;
        end
    end

    always_comb begin
        motor = M_HALT;
        if (btn_sync[0] && !btn_sync[1])      motor = M_FWD;
        else if (btn_sync[1] && !btn_sync[0]) motor = M_BACK;
        servo = S_NONE;
        if (btn_sync[4])                      servo = S_STR;
        else if (btn_sync[2] && !btn_sync[3]) servo = S_LEFT;
        else if (btn_sync[3] && !btn_sync[2]) servo = S_RIGHT;
    end

    assign steer      = (servo == S_LEFT) || (servo == S_RIGHT);
    assign prev_steer = (prev_servo == S_LEFT) || (prev_servo == S_RIGHT);
    assign cmd_byte   = {motor, servo, 2'b00};

    // A direct left<->right swap keeps steer high, so it needs its own term.
    assign trigger = (motor != sent_motor)
                   || (btn_sync[4] && !prev_center)
                   || (steer && !prev_steer)
                   || (steer && prev_steer && (servo != prev_servo))
                   || (steer && (rpt_cnt == RPT_LAST));

    assign tmr_last = (bit_tmr == TMR_LAST);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (pending || trigger) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START:   if (tmr_last) state_d = DATA;
            DATA:    if (tmr_last && (bit_idx == 3'd7)) state_d = STOP;
            STOP:    if (tmr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_servo  <= S_NONE;
            prev_center <= 1'b0;
            rpt_cnt     <= '0;
            pending     <= 1'b0;
        end else begin
            prev_servo  <= servo;
            prev_center <= btn_sync[4];
            if (trigger || !steer) rpt_cnt <= '0;
            else                   rpt_cnt <= rpt_cnt + RW'(1);
            if (load)         pending <= 1'b0;
            else if (trigger) pending <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            last_cmd_q  <= 8'h00;
            cmd_count_q <= 16'h0000;
            sent_motor  <= M_HALT;
            shifter     <= 8'h00;
            bit_tmr     <= '0;
            bit_idx     <= 3'd0;
        end else if (load) begin
            shifter     <= cmd_byte;
            last_cmd_q  <= cmd_byte;
            sent_motor  <= motor;
            cmd_count_q <= cmd_count_q + 16'd1;
            tx_q        <= 1'b0;
            busy_q      <= 1'b1;
            bit_tmr     <= '0;
            bit_idx     <= 3'd0;
        end else if (state != IDLE) begin
            if (tmr_last) begin
                bit_tmr <= '0;
                case (state)
                    START: tx_q <= shifter[0];
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            tx_q <= 1'b1;
                        end else begin
                            tx_q    <= shifter[1];
                            shifter <= {1'b0, shifter[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    STOP:    busy_q <= 1'b0;
                    default: tx_q <= 1'b1;
                endcase
            end else begin
                bit_tmr <= bit_tmr + TW'(1);
            end
        end
    end

    assign bus.tx_pin    = tx_q;
    assign bus.busy      = busy_q;
    assign bus.last_cmd  = last_cmd_q;
    assign bus.cmd_count = cmd_count_q;
    assign bus.state_dbg = state;
endmodule

// File: doc/car_cmd_tx.md
Name: car_cmd_tx

Overview:
- Host-side command transmitter for the car's UART command link.
- Turns five push-button levels into the car's command byte and serialises it as 8N1 on tx_pin.
- Byte format: bits[1:0]=00; [7:5]=motor (011 forward, 110 backward, 101 halt); [4:2]=servo (011 left, 110 right, 101 straight, 000 no change).
- Sits in the remote-control FPGA, driven directly from board buttons.

Parameters:
- SYS_CLK_FREQ, 100_000_000, sys_clk frequency in Hz.
- BAUD_RATE, 921600, line rate; BAUD_DIV = SYS_CLK_FREQ/BAUD_RATE (integer truncation) sys_clk cycles per bit.
- REPEAT_CYCLES, 5_000_000, auto-repeat period in sys_clk cycles while left/right is held.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- btn_fwd  in  1  asynchronous level, 1 = pressed.
- btn_back  in  1  asynchronous level.
- btn_left  in  1  asynchronous level.
- btn_right  in  1  asynchronous level.
- btn_center  in  1  asynchronous level.
- tx_pin  out  1  UART serial output, idle high.
- busy  out  1  high while a frame is on the line.
- last_cmd  out  8  last byte loaded into the shifter.
- cmd_count  out  16  number of frames started; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (async): tx_pin=1, busy=0, last_cmd=8'h00, cmd_count=0, pending=0, sent_motor=101, repeat counter=0, FSM=IDLE.
  - Mid-frame reset forces tx_pin high immediately and discards the frame and the pending flag.
- Every button passes a 2-flop synchroniser. All decode uses the synchronised values, giving 2 cycles latency.
- Motor field M:
  - fwd&~back -> 011.
  - back&~fwd -> 110.
  - otherwise -> 101, including both pressed.
- Servo field S:
  - center -> 101 (center has priority).
  - else left&~right -> 011.
  - else right&~left -> 110.
  - else -> 000.
- steer = S is 011 or 110.
- Triggers, evaluated every cycle, logically OR'd into pending:
  - M != sent_motor.
  - Rising edge of synchronised center.
  - Rising edge of steer, or S changing between 011 and 110.
  - steer held and repeat counter reaching REPEAT_CYCLES-1.
- Repeat counter:
  - Cleared on any trigger and whenever steer=0.
  - Otherwise increments each cycle, independent of busy.
- FSM states IDLE, START, DATA, STOP; bit timer counts 0..BAUD_DIV-1.
  - IDLE: if pending (or a trigger this cycle), load shifter = {M,S,2'b00} using values of this cycle.
    - On load: last_cmd<=byte, sent_motor<=M, cmd_count+=1, pending<=0. Next cycle tx_pin=0, busy=1, go START.
  - START: tx_pin=0 for BAUD_DIV cycles -> DATA.
  - DATA: 8 bits LSB first, BAUD_DIV cycles each -> STOP.
  - STOP: tx_pin=1 for BAUD_DIV cycles. busy drops on the cycle after the final stop cycle (FSM back in IDLE).
- Frame length: exactly 10*BAUD_DIV cycles of busy=1.
- Triggers arriving while busy set pending. Multiple triggers collapse into one frame, and the byte uses button state at load time.
- A pending frame starts on the first IDLE cycle after STOP, so frames are back-to-back with a 1-cycle idle gap.
- A trigger on the IDLE load cycle is consumed by that load.

Test Plan:
- Reset with no buttons, run 2,000,000 cycles -> tx_pin stays 1, cmd_count=0, busy=0.
- Press btn_fwd (SYS_CLK_FREQ=100e6, BAUD_DIV=108).
  - Exactly one frame, byte 0x60: line sequence 0,0,0,0,0,0,1,1,0,1 at 108 cycles/bit.
  - busy high 1080 cycles; last_cmd=0x60, cmd_count=1.
  - Release -> one frame 0xA0.
- Hold btn_left with REPEAT_CYCLES=5000, motor halted.
  - Frame 0xAC at press.
  - Further 0xAC frame starts every 5000 cycles while held.
  - None after release.
- Hold btn_fwd and btn_right together -> 0x78.
- Pulse btn_center while holding right -> 0xB4 frame.
- Press fwd then back 200 cycles apart (second during busy).
  - First frame 0x60, then one 0xC0 frame starting 1 idle cycle after the first stop bit.
  - cmd_count=2.
- Assert rst_n low at bit 4 of a frame -> tx_pin=1 immediately, busy=0, cmd_count=0, no frame resumes after release.
